// File: rtl/aes_encrypt_iter_if.sv
// aes_encrypt_iter_if: valid/ready block handshake for the iterative AES encrypt core.
interface aes_encrypt_iter_if #(
    parameter int KEY_BITS = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [0:127]        plaintext;
    logic [0:KEY_BITS-1] key;
    logic                key_new;
    logic                out_valid;
    logic                out_ready;
    logic [0:127]        ciphertext;

    modport master (
        output in_valid, plaintext, key, key_new, out_ready,
        input  in_ready, out_valid, ciphertext
    );

    modport slave (
        input  in_valid, plaintext, key, key_new, out_ready,
        output in_ready, out_valid, ciphertext
    );
endinterface

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/192/256 encryption, one round per clock, with a stored key schedule.
module aes_encrypt_iter #(
    parameter int KEY_BITS = 128
) (
    input logic               clk,
    input logic               reset,
    aes_encrypt_iter_if.slave bus
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int W = 4 * (NR + 1);

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} st_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (y[0] ? x : 8'h00);
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, with 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s, r;
        s = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    st_t                st_q, st_d;
    logic [0:15][7:0]   state_q, state_d, sr, mc, rk, rnd_out;
    logic [0:W-1][31:0] w_q, w_d;
    logic [3:0]         rnd_q, rnd_d;
    logic [5:0]         widx_q, widx_d, ri;
    logic [2:0]         kcnt_q, kcnt_d;
    logic [7:0]         rc_q, rc_d;
    logic [127:0]       ct_q, ct_d;
    logic               sched_q, sched_d, ov_q, ov_d, accept;
    logic [31:0]        tmp, sub, w_new;

    assign bus.in_ready   = reset && (st_q == IDLE || (st_q == DONE && bus.out_ready));
    assign bus.out_valid  = ov_q;
    assign bus.ciphertext = ct_q;
    assign accept         = bus.in_valid && bus.in_ready;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sbox(state_q[4*((c+r)%4)+r]);
            assign mc[4*c+r] = xt(sr[4*c+r]) ^ xt(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                             ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
        end
    end

    assign ri      = {rnd_q, 2'b00};
    assign rk      = {w_q[ri], w_q[ri+6'd1], w_q[ri+6'd2], w_q[ri+6'd3]};
    assign rnd_out = (rnd_q == 4'(NR) ? sr : mc) ^ rk;

    // kcnt_q tracks i mod Nk and rc_q the next Rcon byte, avoiding a divider
    assign tmp   = w_q[widx_q-6'd1];
    assign sub   = subw(kcnt_q == 3'd0 ? {tmp[23:0], tmp[31:24]} : tmp);
    assign w_new = w_q[widx_q-6'(NK)] ^ (kcnt_q == 3'd0 ? sub ^ {rc_q, 24'h0} :
                   (NK == 8 && kcnt_q == 3'd4) ? sub : tmp);

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        w_d     = w_q;
        rnd_d   = rnd_q;
        widx_d  = widx_q;
        kcnt_d  = kcnt_q;
        rc_d    = rc_q;
        ct_d    = ct_q;
        sched_d = sched_q;
        ov_d    = ov_q;
        if (st_q == KEYEXP) begin
            w_d[widx_q] = w_new;
            widx_d      = widx_q + 6'd1;
            kcnt_d      = kcnt_q == 3'(NK - 1) ? 3'd0 : kcnt_q + 3'd1;
            rc_d        = kcnt_q == 3'd0 ? xt(rc_q) : rc_q;
            if (widx_q == 6'(W - 1)) begin
                sched_d = 1'b1;
                st_d    = ROUND;
            end
        end
        if (st_q == ROUND) begin
            state_d = rnd_out;
            rnd_d   = rnd_q + 4'd1;
            if (rnd_q == 4'(NR)) begin
                ct_d = rnd_out;
                ov_d = 1'b1;
                st_d = DONE;
            end
        end
        if (st_q == DONE && bus.out_ready) begin
            ov_d = 1'b0;
            st_d = IDLE;
        end
        if (accept) begin
            state_d = bus.plaintext ^ bus.key[0:127];
            rnd_d   = 4'd1;
            st_d    = ROUND;
            if (bus.key_new || !sched_q) begin
                w_d     = {bus.key, {(W * 32 - KEY_BITS){1'b0}}};
                widx_d  = 6'(NK);
                kcnt_d  = 3'd0;
                rc_d    = 8'h01;
                sched_d = 1'b0;
                st_d    = KEYEXP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q    <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            widx_q  <= '0;
            kcnt_q  <= '0;
            rc_q    <= '0;
            ct_q    <= '0;
            sched_q <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            widx_q  <= widx_d;
            kcnt_q  <= kcnt_d;
            rc_q    <= rc_d;
            ct_q    <= ct_d;
            sched_q <= sched_d;
            ov_q    <= ov_d;
        end
        w_q <= w_d;
    end
endmodule
